// File: rtl/ann_pkg.sv
// Shared definitions for the ANN weight path: default row geometry, fetch FSM
// encoding and the FIFO credit rule used by the weight fetch controller.
package ann_pkg;

    localparam int WEIGHT_W  = 16;
    localparam int ROW_DEPTH = 28;
    localparam int WADDR_W   = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    // A read may be issued only if the words already held or in flight, less the
    // one leaving on this edge, leave a free slot in the 2-entry skid FIFO.
    function automatic logic fifo_has_credit(input logic [1:0] cnt,
                                             input logic       pending,
                                             input logic       pop);
        logic [2:0] occ;
        occ = {1'b0, cnt} + {2'b00, pending} - {2'b00, pop};
        return (occ < 3'd2);
    endfunction

endpackage

// File: rtl/weight_skid_fifo.sv
// Two-entry FIFO that absorbs BRAM read data while the weight stream is stalled.
// Simultaneous push and pop keep the count unchanged and preserve order.
module weight_skid_fifo #(
    parameter int W = 22
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_dout,
    output logic [1:0]   o_cnt
);

    logic [W-1:0] r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_cnt;
    logic         w_pop;
    logic         w_push;

    assign w_pop  = i_pop && (r_cnt != 2'd0);
    assign w_push = i_push && ((r_cnt != 2'd2) || w_pop);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_cnt    <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign o_dout = r_mem[r_rd_ptr];
    assign o_cnt  = r_cnt;

endmodule

// File: rtl/weight_fetch_ctrl.sv
// Read-side master for one weight BRAM bank: fetches a row of DEPTH words on START
// and streams them over valid/ready with index and LAST tags.
module weight_fetch_ctrl
    import ann_pkg::*;
#(
    parameter int DEPTH  = ROW_DEPTH,
    parameter int ADDR_W = WADDR_W,
    parameter int DATA_W = WEIGHT_W,
    parameter int BASE   = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    output logic              BUSY,
    output logic              DONE,
    output logic [ADDR_W-1:0] ADDR,
    output logic              EN,
    output logic              WE,
    output logic [DATA_W-1:0] DI,
    input  logic [DATA_W-1:0] DO_IN,
    output logic [DATA_W-1:0] W_DATA,
    output logic [ADDR_W-1:0] W_IDX,
    output logic              W_LAST,
    output logic              W_VALID,
    input  logic              W_READY
);

    localparam int               CNT_W    = ADDR_W + 1;
    localparam int               FW       = DATA_W + ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

    fetch_state_e      r_state;
    fetch_state_e      w_state_nxt;
    logic [CNT_W-1:0]  r_issue_cnt;
    logic              r_pending;
    logic [ADDR_W-1:0] r_pend_idx;
    logic              r_pend_last;
    logic [ADDR_W-1:0] r_addr;
    logic              r_en;
    logic              r_done;

    logic              w_issue;
    logic              w_busy;
    logic              w_pop;
    logic              w_valid;
    logic              w_credit;
    logic              w_last_issue;
    logic              w_last_pop;
    logic [1:0]        w_fifo_cnt;
    logic [FW-1:0]     w_fifo_din;
    logic [FW-1:0]     w_fifo_dout;

    assign w_valid      = (w_fifo_cnt != 2'd0);
    assign w_pop        = w_valid && W_READY;
    assign w_credit     = fifo_has_credit(w_fifo_cnt, r_pending, w_pop);
    assign w_last_issue = (r_issue_cnt == LAST_CNT);
    assign w_last_pop   = w_pop && w_fifo_dout[0];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (START) w_state_nxt = (DEPTH == 1) ? ST_DRAIN : ST_FETCH;
            ST_FETCH: if (w_credit && w_last_issue) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_last_pop) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // The first read goes out on the START edge itself; the FIFO is always empty in IDLE.
    always_comb begin
        w_busy  = (r_state != ST_IDLE);
        w_issue = 1'b0;
        case (r_state)
            ST_IDLE:  w_issue = START;
            ST_FETCH: w_issue = w_credit;
            default:  w_issue = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_issue_cnt <= '0;
            r_pending   <= 1'b0;
            r_pend_idx  <= '0;
            r_pend_last <= 1'b0;
            r_addr      <= ADDR_W'(BASE);
            r_en        <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_en      <= w_issue;
            r_pending <= w_issue;
            r_done    <= (r_state == ST_DRAIN) && w_last_pop;
            if (w_issue) begin
                r_addr      <= ADDR_W'(BASE) + r_issue_cnt[ADDR_W-1:0];
                r_pend_idx  <= r_issue_cnt[ADDR_W-1:0];
                r_pend_last <= w_last_issue;
                r_issue_cnt <= w_last_issue ? '0 : r_issue_cnt + 1'b1;
            end
        end
    end

    // The BRAM drives DO_IN on the negedge after an issue; it is captured with its tags here.
    assign w_fifo_din = {DO_IN, r_pend_idx, r_pend_last};

    weight_skid_fifo #(
        .W (FW)
    ) u_fifo (
        .i_clk  (CLK),
        .i_rst  (RST),
        .i_push (r_pending),
        .i_din  (w_fifo_din),
        .i_pop  (w_pop),
        .o_dout (w_fifo_dout),
        .o_cnt  (w_fifo_cnt)
    );

    assign BUSY    = w_busy;
    assign DONE    = r_done;
    assign ADDR    = r_addr;
    assign EN      = r_en;
    assign WE      = 1'b0;
    assign DI      = '0;
    assign W_DATA  = w_fifo_dout[FW-1 -: DATA_W];
    assign W_IDX   = w_fifo_dout[ADDR_W:1];
    assign W_LAST  = w_fifo_dout[0];
    assign W_VALID = w_valid;

endmodule
